// File: rtl/alu_muldiv_riscv.sv
// rtl/alu_muldiv_riscv.sv - RV32/64 base ALU with iterative M-extension multiply/divide
// Optional macro ALU_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
module alu_muldiv_riscv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            Start,
   input  logic            Mul_Div,
   input  logic [4:0]      Operation,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic [XLEN-1:0] Result,
   output logic            Flag,
   output logic            Busy,
   output logic            Done
);

   localparam int SW = $clog2(XLEN);
   localparam int CW = SW + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_SLL = 5'b00010;
   localparam logic [4:0] ALU_SRL = 5'b00011;
   localparam logic [4:0] ALU_SRA = 5'b00100;
   localparam logic [4:0] ALU_XOR = 5'b00101;
   localparam logic [4:0] ALU_OR  = 5'b00110;
   localparam logic [4:0] ALU_AND = 5'b00111;
   localparam logic [4:0] ALU_EQ  = 5'b10000;
   localparam logic [4:0] ALU_NE  = 5'b10001;
   localparam logic [4:0] ALU_LTS = 5'b10010;
   localparam logic [4:0] ALU_LTU = 5'b10011;
   localparam logic [4:0] ALU_GES = 5'b10100;
   localparam logic [4:0] ALU_GEU = 5'b10101;

   logic [1:0]        r_state;
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_a;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_mcand;
   logic [CW-1:0]     r_cnt;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_div_zero;
   logic [XLEN-1:0]   r_result;
   logic              r_flag;

   logic [SW-1:0]     w_shamt;
   logic [XLEN-1:0]   w_alu_res;
   logic              w_alu_flag;
   logic [2:0]        w_f3;
   logic              w_sa;
   logic              w_sb;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_diff;
   logic [2*XLEN-1:0] w_acc_nxt;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_md_res;

   assign w_shamt = B[SW-1:0];

   always_comb begin
      w_alu_res = '0;
      case (Operation)
         ALU_ADD: w_alu_res = A + B;
         ALU_SUB: w_alu_res = A - B;
         ALU_SLL: w_alu_res = A << w_shamt;
         ALU_SRL: w_alu_res = A >> w_shamt;
         ALU_SRA: w_alu_res = $signed(A) >>> w_shamt;
         ALU_XOR: w_alu_res = A ^ B;
         ALU_OR:  w_alu_res = A | B;
         ALU_AND: w_alu_res = A & B;
         ALU_EQ:  w_alu_res = {{(XLEN-1){1'b0}}, A == B};
         ALU_NE:  w_alu_res = {{(XLEN-1){1'b0}}, A != B};
         ALU_LTS: w_alu_res = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
         ALU_LTU: w_alu_res = {{(XLEN-1){1'b0}}, A < B};
         ALU_GES: w_alu_res = {{(XLEN-1){1'b0}}, $signed(A) >= $signed(B)};
         ALU_GEU: w_alu_res = {{(XLEN-1){1'b0}}, A >= B};
         default: w_alu_res = '0;
      endcase
   end

   assign w_alu_flag = Operation[4] & w_alu_res[0];

   // Iterate on magnitudes; signs are reapplied once the last step completes.
   assign w_f3    = Operation[2:0];
   assign w_sa    = A[XLEN-1] & ((w_f3 == 3'b001) | (w_f3 == 3'b010) | (w_f3 == 3'b100) | (w_f3 == 3'b110));
   assign w_sb    = B[XLEN-1] & ((w_f3 == 3'b001) | (w_f3 == 3'b100) | (w_f3 == 3'b110));
   assign w_mag_a = w_sa ? (~A + 1'b1) : A;
   assign w_mag_b = w_sb ? (~B + 1'b1) : B;

   assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
   assign w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_mcand};

   always_comb begin
      w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
      if (r_op[2]) begin
         if (w_diff[XLEN])
            w_acc_nxt = {r_acc[2*XLEN-2:0], 1'b0};
         else
            w_acc_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end
   end

   assign w_prod = r_neg_q ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
   assign w_quo  = r_div_zero ? {XLEN{1'b1}} :
                   (r_neg_q ? (~w_acc_nxt[XLEN-1:0] + 1'b1) : w_acc_nxt[XLEN-1:0]);
   assign w_rem  = r_div_zero ? r_a :
                   (r_neg_r ? (~w_acc_nxt[2*XLEN-1:XLEN] + 1'b1) : w_acc_nxt[2*XLEN-1:XLEN]);

   always_comb begin
      w_md_res = '0;
      case (r_op)
         3'b000:                  w_md_res = w_prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011:  w_md_res = w_prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:          w_md_res = w_quo;
         default:                 w_md_res = w_rem;
      endcase
   end

`ifdef ALU_DIV_EARLY_OUT_EN
   logic            w_b_zero;
   logic            w_special;
   logic [XLEN-1:0] w_special_res;
   assign w_b_zero  = (B == '0);
   assign w_special = Mul_Div & Operation[2] &
                      (w_b_zero | (~Operation[0] & (A == {1'b1, {(XLEN-1){1'b0}}}) & (B == {XLEN{1'b1}})));
   assign w_special_res = Operation[1] ? (w_b_zero ? A : '0) : (w_b_zero ? {XLEN{1'b1}} : A);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_a        <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_cnt      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
         r_result   <= '0;
         r_flag     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_op       <= w_f3;
                  r_a        <= A;
                  r_cnt      <= '0;
                  r_div_zero <= (B == '0);
                  r_neg_q    <= w_sa ^ w_sb;
                  r_neg_r    <= w_sa;
                  if (!Mul_Div) begin
                     r_result <= w_alu_res;
                     r_flag   <= w_alu_flag;
                     r_state  <= S_DONE;
                  end
`ifdef ALU_DIV_EARLY_OUT_EN
                  else if (w_special) begin
                     r_result <= w_special_res;
                     r_flag   <= 1'b0;
                     r_state  <= S_DONE;
                  end
`endif
                  else begin
                     r_acc   <= Operation[2] ? {{XLEN{1'b0}}, w_mag_a} : {{XLEN{1'b0}}, w_mag_b};
                     r_mcand <= Operation[2] ? w_mag_b : w_mag_a;
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(XLEN-1)) begin
                  r_result <= w_md_res;
                  r_flag   <= 1'b0;
                  r_state  <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Result = r_result;
   assign Flag   = r_flag;
   assign Busy   = (r_state != S_IDLE);
   assign Done   = (r_state == S_DONE);

endmodule

// File: tb/tb_alu_muldiv_riscv.sv
// tb/tb_alu_muldiv_riscv.sv - directed bench for alu_muldiv_riscv (XLEN=32)
module tb_alu_muldiv_riscv;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_SLL = 5'b00010;
   localparam logic [4:0] ALU_SRL = 5'b00011;
   localparam logic [4:0] ALU_SRA = 5'b00100;
   localparam logic [4:0] ALU_XOR = 5'b00101;
   localparam logic [4:0] ALU_EQ  = 5'b10000;
   localparam logic [4:0] ALU_LTS = 5'b10010;
   localparam logic [4:0] ALU_LTU = 5'b10011;
   localparam logic [4:0] ALU_GEU = 5'b10101;

   localparam logic [4:0] M_MUL    = 5'b00000;
   localparam logic [4:0] M_MULH   = 5'b00001;
   localparam logic [4:0] M_MULHSU = 5'b00010;
   localparam logic [4:0] M_MULHU  = 5'b00011;
   localparam logic [4:0] M_DIV    = 5'b00100;
   localparam logic [4:0] M_DIVU   = 5'b00101;
   localparam logic [4:0] M_REM    = 5'b00110;
   localparam logic [4:0] M_REMU   = 5'b00111;

`ifdef ALU_DIV_EARLY_OUT_EN
   localparam int SPEC_LAT = 1;
`else
   localparam int SPEC_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        Start;
   logic        Mul_Div;
   logic [4:0]  Operation;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] Result;
   logic        Flag;
   logic        Busy;
   logic        Done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_muldiv_riscv #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .Start     (Start),
      .Mul_Div   (Mul_Div),
      .Operation (Operation),
      .A         (A),
      .B         (B),
      .Result    (Result),
      .Flag      (Flag),
      .Busy      (Busy),
      .Done      (Done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic md, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] res, input logic flg);
      int n;
      @(negedge clk);
      Start = 1'b1; Mul_Div = md; Operation = op; A = a; B = b;
      @(negedge clk);
      Start = 1'b0; A = $urandom; B = $urandom;
      chk({tag, ".busy"}, {31'd0, Busy}, 32'd1);
      n = 1;
      while (!Done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".lat"}, n, lat);
      chk({tag, ".res"}, Result, res);
      chk({tag, ".flag"}, {31'd0, Flag}, {31'd0, flg});
      @(negedge clk);
      chk({tag, ".done_pulse"}, {30'd0, Done, Busy}, 32'd0);
   endtask

   initial begin
      int dones;
      logic [31:0] seen;
      rst = 1'b1; Start = 1'b0; Mul_Div = 1'b0; Operation = '0; A = '0; B = '0;
      repeat (3) @(negedge clk);
      chk("reset.outs", {Result[29:0], Flag, Busy}, 32'd0);
      chk("reset.done", {31'd0, Done}, 32'd0);
      rst = 1'b0;

      run_op("add",   1'b0, ALU_ADD, 32'd5, 32'd7, 1, 32'd12, 1'b0);
      run_op("sub",   1'b0, ALU_SUB, 32'd5, 32'd7, 1, 32'hFFFFFFFE, 1'b0);
      run_op("sll",   1'b0, ALU_SLL, 32'd1, 32'd33, 1, 32'd2, 1'b0);
      run_op("srl",   1'b0, ALU_SRL, 32'h80000000, 32'd4, 1, 32'h08000000, 1'b0);
      run_op("sra",   1'b0, ALU_SRA, 32'h80000000, 32'd4, 1, 32'hF8000000, 1'b0);
      run_op("xor",   1'b0, ALU_XOR, 32'h0000F0F0, 32'h0000FF00, 1, 32'h00000FF0, 1'b0);
      run_op("lts",   1'b0, ALU_LTS, 32'hFFFFFFFF, 32'd1, 1, 32'd1, 1'b1);
      run_op("ltu",   1'b0, ALU_LTU, 32'hFFFFFFFF, 32'd1, 1, 32'd0, 1'b0);
      run_op("eq",    1'b0, ALU_EQ,  32'd3, 32'd3, 1, 32'd1, 1'b1);
      run_op("geu",   1'b0, ALU_GEU, 32'hFFFFFFFF, 32'd1, 1, 32'd1, 1'b1);
      run_op("undef", 1'b0, 5'b11111, 32'd9, 32'd9, 1, 32'd0, 1'b0);

      run_op("mulh",   1'b1, M_MULH,   32'h80000000, 32'h80000000, 33, 32'h40000000, 1'b0);
      run_op("mulhu",  1'b1, M_MULHU,  32'h80000000, 32'h80000000, 33, 32'h40000000, 1'b0);
      run_op("mul0",   1'b1, M_MUL,    32'h80000000, 32'h80000000, 33, 32'd0, 1'b0);
      run_op("mul",    1'b1, 5'b11000, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFEB, 1'b0);
      run_op("mulhsu", 1'b1, M_MULHSU, 32'hFFFFFFFF, 32'd2, 33, 32'hFFFFFFFF, 1'b0);
      run_op("div",    1'b1, M_DIV,    32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 1'b0);
      run_op("rem",    1'b1, M_REM,    32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 1'b0);
      run_op("divu",   1'b1, M_DIVU,   32'd100, 32'd7, 33, 32'd14, 1'b0);
      run_op("remu",   1'b1, M_REMU,   32'd100, 32'd7, 33, 32'd2, 1'b0);

      run_op("divu0",  1'b1, M_DIVU, 32'h00001234, 32'd0, SPEC_LAT, 32'hFFFFFFFF, 1'b0);
      run_op("remu0",  1'b1, M_REMU, 32'h00001234, 32'd0, SPEC_LAT, 32'h00001234, 1'b0);
      run_op("div0",   1'b1, M_DIV,  32'hFFFFFFFB, 32'd0, SPEC_LAT, 32'hFFFFFFFF, 1'b0);
      run_op("rem0",   1'b1, M_REM,  32'hFFFFFFFB, 32'd0, SPEC_LAT, 32'hFFFFFFFB, 1'b0);
      run_op("divovf", 1'b1, M_DIV,  32'h80000000, 32'hFFFFFFFF, SPEC_LAT, 32'h80000000, 1'b0);
      run_op("removf", 1'b1, M_REM,  32'h80000000, 32'hFFFFFFFF, SPEC_LAT, 32'd0, 1'b0);

      // Reset in the middle of a divide: aborts silently.
      run_op("pre_rst", 1'b0, ALU_ADD, 32'd1, 32'd2, 1, 32'd3, 1'b0);
      @(negedge clk);
      Start = 1'b1; Mul_Div = 1'b1; Operation = M_DIVU; A = 32'd100; B = 32'd7;
      @(negedge clk);
      Start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort.busy", {31'd0, Busy}, 32'd0);
      chk("abort.result", Result, 32'd0);
      chk("abort.done", {31'd0, Done}, 32'd0);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (Done) dones++;
      end
      chk("abort.no_done", dones, 32'd0);

      // Reset wins over a simultaneous Start.
      run_op("pre_rst2", 1'b0, ALU_ADD, 32'd4, 32'd4, 1, 32'd8, 1'b0);
      @(negedge clk);
      rst = 1'b1; Start = 1'b1; Mul_Div = 1'b0; Operation = ALU_ADD; A = 32'd1; B = 32'd1;
      @(negedge clk);
      rst = 1'b0; Start = 1'b0;
      chk("rst_prio", {Result[29:0], Busy, Done}, 32'd0);

      // Start held through CALC with changing operands: one op, first operands.
      @(negedge clk);
      Start = 1'b1; Mul_Div = 1'b1; Operation = M_MUL; A = 32'd6; B = 32'd7;
      dones = 0; seen = '0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (i == 20) Start = 1'b0;
         else if (Start) begin A = $urandom; B = $urandom; end
         if (Done) begin dones++; seen = Result; end
      end
      chk("held.dones", dones, 32'd1);
      chk("held.result", seen, 32'd42);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_muldiv_riscv.md
ALU_MULDIV_RISCV -- requirements
Module: alu_muldiv_riscv

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand and result width; power of two, 8..64.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: Start  in  1  operation request; accepted only when Busy=0.
REQ-005 SHALL have port: Mul_Div  in  1  0 = base ALU op, 1 = RV M-extension op.
REQ-006 SHALL have port: Operation  in  5  Mul_Div=0: ALU_* encodings from defines.v; Mul_Div=1: bits[2:0] = funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), bits[4:3] ignored.
REQ-007 SHALL have ports: A, B  in  XLEN  operands.
REQ-008 SHALL have port: Result  out  XLEN  registered result.
REQ-009 SHALL have port: Flag  out  1  registered compare/branch flag.
REQ-010 SHALL have port: Busy  out  1  high while an accepted operation is in flight.
REQ-011 SHALL have port: Done  out  1  one-cycle pulse; Result/Flag valid from this cycle.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; Busy = (state != IDLE).
REQ-013 SHALL, in IDLE with Start=1, latch A, B, Operation, Mul_Div; go to DONE for base ops, CALC for M ops.
REQ-014 SHALL ignore Start while Busy=1; inputs sampled only at acceptance.
REQ-015 SHALL give base ops latency 1: Done high the cycle after the Start cycle.
REQ-016 SHALL compute M ops iteratively, one bit per cycle, XLEN cycles in CALC, Done exactly XLEN+1 cycles after the Start cycle.
REQ-017 SHALL stay in DONE one cycle (Done=1), then return to IDLE; max throughput one base op per 2 cycles.
REQ-018 SHALL hold Result and Flag stable from Done until the next accepted operation's Done.
REQ-019 SHALL use only B[log2(XLEN)-1:0] as shift amount for SLL/SRL/SRA.
REQ-020 SHALL set Flag = Result[0] for base ops with Operation[4]=1, else Flag=0; Flag=0 for all M ops.
REQ-021 SHALL return low XLEN bits of product for MUL; high XLEN bits of 2*XLEN product for MULH (s*s), MULHSU (s*u), MULHU (u*u).
REQ-022 SHALL round DIV/DIVU quotients toward zero; REM sign = dividend sign.
REQ-023 SHALL, for divisor 0: quotient all ones, remainder = A.
REQ-024 SHALL, for DIV/REM with A = most-negative and B = -1: quotient = A, remainder = 0.
REQ-025 SHALL treat undefined base encodings as Result=0, Flag=0, latency 1.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, go to IDLE and drive Result=0, Flag=0, Busy=0, Done=0.
REQ-027 SHALL give rst priority over Start in the same cycle.
REQ-028 SHALL abort an in-flight CALC on rst without ever pulsing Done for it.

Configuration
REQ-029 SHALL support macro ALU_DIV_EARLY_OUT_EN.
REQ-030 SHALL, with ALU_DIV_EARLY_OUT_EN defined, complete divide-by-zero and signed-overflow cases (REQ-023/024) as base ops: IDLE->DONE, Done one cycle after Start.
REQ-031 SHALL, without the macro, run those cases through CALC, latency XLEN+1, same values.

Verification (XLEN=32)
REQ-032 ADD A=5,B=7 -> Done next cycle, Result=12, Flag=0; LTS A=0xFFFFFFFF,B=1 -> Result=1, Flag=1.
REQ-033 MULH A=B=0x80000000 -> Result=0x40000000, Done 33 cycles after Start; MULHU same operands -> 0x40000000; MUL -> 0.
REQ-034 DIV A=-7,B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU A=100,B=7 -> 14; REMU -> 2.
REQ-035 DIVU A=0x1234,B=0 -> 0xFFFFFFFF; REMU -> 0x1234; DIV A=0x80000000,B=-1 -> 0x80000000; Done at +1 cycle with macro, +33 without.
REQ-036 rst asserted 10 cycles into DIV -> Busy=0, Result=0 next cycle, no Done; Start held during CALC -> ignored, exactly one Done per accepted op.
